// File: rtl/router_pkg.sv
// Shared types for the router ingress controller:
// state encoding, header layout, control strobes.
package router_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int LEN_W  = DATA_W - ADDR_W;
  localparam int NPORT  = 3;

  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR
  } state_e;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } hdr_t;

  // One-cycle datapath commands from the FSM.
  typedef struct packed {
    logic hdr_ld;
    logic lfd_wr;
    logic pay_wr;
    logic hold_ld;
    logic laf_wr;
    logic par_wr;
  } ctl_t;

  function automatic logic [NPORT-1:0] port_sel(
    input logic [ADDR_W-1:0] a
  );
    logic [NPORT-1:0] s;
    s = '0;
    unique case (a)
      2'd0:    s = 3'b001;
      2'd1:    s = 3'b010;
      2'd2:    s = 3'b100;
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/router_ingress_ctrl_if.sv
// Ingress bus: source byte stream, FIFO status/abort
// in; registered FIFO write port and status out.
interface router_ingress_ctrl_if;

  logic                         pkt_valid;
  logic [router_pkg::DATA_W-1:0] data_in;
  logic [router_pkg::NPORT-1:0]  fifo_full;
  logic [router_pkg::NPORT-1:0]  fifo_empty;
  logic [router_pkg::NPORT-1:0]  soft_reset;
  logic [router_pkg::DATA_W-1:0] data_out;
  logic [router_pkg::NPORT-1:0]  write_en;
  logic                         lfd_state;
  logic                         busy;
  logic                         err;
  logic                         parity_done;

  modport master (
    output pkt_valid, data_in,
    output fifo_full, fifo_empty, soft_reset,
    input  data_out, write_en, lfd_state,
    input  busy, err, parity_done
  );

  modport slave (
    input  pkt_valid, data_in,
    input  fifo_full, fifo_empty, soft_reset,
    output data_out, write_en, lfd_state,
    output busy, err, parity_done
  );

endinterface

// File: rtl/router_ingress_fsm.sv
// 8-state packet controller. In: valid, header addr,
// FIFO status, aborts. Out: datapath strobes, busy.
module router_ingress_fsm
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [ADDR_W-1:0] addr_q,
  input  logic [NPORT-1:0]  fifo_full,
  input  logic [NPORT-1:0]  fifo_empty,
  input  logic [NPORT-1:0]  soft_reset,
  output ctl_t              ctl,
  output logic              busy
);

  state_e state_q, state_d;

  logic [NPORT-1:0] sel;
  logic             full;
  logic             empty;
  logic             abort;
  logic             in_empty;

  assign sel      = port_sel(addr_q);
  assign full     = |(fifo_full & sel);
  assign empty    = |(fifo_empty & sel);
  assign abort    = |(soft_reset & sel);
  assign in_empty = |(fifo_empty & port_sel(in_addr));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= DECODE_ADDRESS;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctl     = '0;
    busy    = 1'b1;
    unique case (state_q)
      DECODE_ADDRESS: begin
        busy = 1'b0;
        if (pkt_valid && in_addr != ADDR_INVALID) begin
          ctl.hdr_ld = 1'b1;
          state_d = in_empty ? LOAD_FIRST_DATA
                             : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (empty) state_d = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: begin
        ctl.lfd_wr = 1'b1;
        state_d    = LOAD_DATA;
      end
      LOAD_DATA: begin
        busy = 1'b0;
        if (!pkt_valid) begin
          state_d = LOAD_PARITY;
        end else if (full) begin
          // byte is taken but parked until room
          ctl.hold_ld = 1'b1;
          state_d     = FIFO_FULL_STATE;
        end else begin
          ctl.pay_wr = 1'b1;
        end
      end
      FIFO_FULL_STATE: begin
        if (!full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        ctl.laf_wr = 1'b1;
        state_d = pkt_valid ? LOAD_DATA
                            : LOAD_PARITY;
      end
      LOAD_PARITY: begin
        ctl.par_wr = 1'b1;
        state_d    = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        state_d = DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    // abort drops any write launched this edge
    if (abort && state_q != DECODE_ADDRESS) begin
      state_d = DECODE_ADDRESS;
      ctl     = '0;
    end
  end

endmodule

// File: rtl/router_ingress_ctrl.sv
// Router ingress: header/hold/parity datapath around
// router_ingress_fsm. Ports: clock, resetn, bus (slave).
// Optional parity check: ROUTER_PARITY_CHECK_EN.
module router_ingress_ctrl
  import router_pkg::*;
(
  input logic                  clock,
  input logic                  resetn,
  router_ingress_ctrl_if.slave bus
);

  ctl_t ctl;
  logic busy;
  hdr_t in_hdr;

  hdr_t              hdr_q, hdr_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [NPORT-1:0]  write_en_q, write_en_d;
  logic              lfd_q, lfd_d;
  logic              pdone_q, pdone_d;
  logic [NPORT-1:0]  sel;

  assign in_hdr = hdr_t'(bus.data_in);
  assign sel    = port_sel(hdr_q.addr);

  router_ingress_fsm u_fsm (
    .clock      (clock),
    .resetn     (resetn),
    .pkt_valid  (bus.pkt_valid),
    .in_addr    (in_hdr.addr),
    .addr_q     (hdr_q.addr),
    .fifo_full  (bus.fifo_full),
    .fifo_empty (bus.fifo_empty),
    .soft_reset (bus.soft_reset),
    .ctl        (ctl),
    .busy       (busy)
  );

`ifdef ROUTER_PARITY_CHECK_EN
  logic [DATA_W-1:0] par_q, par_d;
  logic              err_q, err_d;
`endif

  always_comb begin
    hdr_d      = hdr_q;
    hold_d     = hold_q;
    data_out_d = data_out_q;
    write_en_d = '0;
    lfd_d      = 1'b0;
    pdone_d    = ctl.par_wr;
    if (ctl.hdr_ld)  hdr_d  = in_hdr;
    if (ctl.hold_ld) hold_d = bus.data_in;
    if (ctl.lfd_wr) begin
      data_out_d = hdr_q;
      write_en_d = sel;
      lfd_d      = 1'b1;
    end
    if (ctl.pay_wr || ctl.par_wr) begin
      data_out_d = bus.data_in;
      write_en_d = sel;
    end
    if (ctl.laf_wr) begin
      data_out_d = hold_q;
      write_en_d = sel;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hdr_q      <= '0;
      hold_q     <= '0;
      data_out_q <= '0;
      write_en_q <= '0;
      lfd_q      <= 1'b0;
      pdone_q    <= 1'b0;
    end else begin
      hdr_q      <= hdr_d;
      hold_q     <= hold_d;
      data_out_q <= data_out_d;
      write_en_q <= write_en_d;
      lfd_q      <= lfd_d;
      pdone_q    <= pdone_d;
    end
  end

`ifdef ROUTER_PARITY_CHECK_EN
  // running XOR over header and every accepted
  // payload byte, held ones included
  always_comb begin
    par_d = par_q;
    err_d = err_q;
    if (ctl.hdr_ld) begin
      par_d = bus.data_in;
      err_d = 1'b0;
    end
    if (ctl.pay_wr || ctl.hold_ld)
      par_d = par_q ^ bus.data_in;
    if (ctl.par_wr)
      err_d = (par_q != bus.data_in);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      par_q <= '0;
      err_q <= 1'b0;
    end else begin
      par_q <= par_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.data_out    = data_out_q;
  assign bus.write_en    = write_en_q;
  assign bus.lfd_state   = lfd_q;
  assign bus.busy        = busy;
  assign bus.parity_done = pdone_q;

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// Self-checking bench for router_ingress_ctrl:
// packet table plus reset / addr-3 sequences.
module tb_router_ingress_ctrl;
  import router_pkg::*;

`ifdef ROUTER_PARITY_CHECK_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  router_ingress_ctrl_if bus ();

  router_ingress_ctrl dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] d;
    logic       lfd;
    logic [2:0] we;
  } wr_t;

  typedef struct {
    logic [7:0] hdr;
    int         npay;
    int         empty_dly;
    int         full_at;
    int         full_cyc;
    int         sr_at;
    bit         bad_par;
    int         exp_wr;
    logic [2:0] exp_we;
    int         exp_pd;
    logic       exp_err;
  } vec_t;

  wr_t        log_q[$];
  int         pd_cnt    = 0;
  int         viol_cnt  = 0;
  logic       err_at_pd = 1'b0;
  logic [2:0] full_edge = '0;
  bit         wte_phase = 1'b0;
  int         empty_cnt = 0;
  int         full_cnt  = 0;

  always @(posedge clock) full_edge <= bus.fifo_full;

  always @(negedge clock) begin
    if (bus.write_en != 3'b000) begin
      log_q.push_back('{bus.data_out,
                        bus.lfd_state,
                        bus.write_en});
      if ($countones(bus.write_en) != 1)
        viol_cnt++;
      if ((bus.write_en & full_edge) != 0)
        viol_cnt++;
      if (wte_phase) viol_cnt++;
    end
    if (wte_phase && bus.busy !== 1'b1)
      viol_cnt++;
    if (bus.parity_done === 1'b1) begin
      pd_cnt++;
      err_at_pd = bus.err;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic tick(output bit acc);
    logic b;
    @(negedge clock);
    b = bus.busy;
    @(posedge clock);
    #1;
    acc = (b === 1'b0);
    if (empty_cnt > 0) begin
      empty_cnt--;
      if (empty_cnt == 0) begin
        bus.fifo_empty = 3'b111;
        wte_phase = 1'b0;
      end
    end
    if (full_cnt > 0) begin
      full_cnt--;
      if (full_cnt == 0) bus.fifo_full = '0;
    end
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) tick(a);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           output int to);
    bit acc;
    acc = 1'b0;
    bus.pkt_valid = 1'b1;
    bus.data_in   = b;
    for (int k = 0; k < 40 && !acc; k++)
      tick(acc);
    to = acc ? 0 : 1;
  endtask

  function automatic logic [7:0] pay(
    input logic [7:0] h, input int i);
    return 8'(h + 8'(i * 29) + 8'h5);
  endfunction

  task automatic run_packet(input vec_t v,
                            input string tag);
    logic [7:0] exp_b[$];
    logic [7:0] par;
    logic [2:0] sel;
    logic [2:0] we_or;
    int to, tmo, pd0, seq_bad, lfd_n;
    bit aborted, got;
    log_q.delete();
    viol_cnt = 0;
    pd0 = pd_cnt;
    tmo = 0;
    sel = port_sel(v.hdr[1:0]);
    exp_b.push_back(v.hdr);
    par = v.hdr;
    for (int i = 1; i <= v.npay; i++) begin
      exp_b.push_back(pay(v.hdr, i));
      par ^= pay(v.hdr, i);
    end
    if (v.bad_par) par = ~par;
    exp_b.push_back(par);
    if (v.empty_dly > 0) begin
      bus.fifo_empty = ~sel;
      empty_cnt = v.empty_dly;
    end
    send_byte(v.hdr, to);
    tmo += to;
    wte_phase = (empty_cnt > 0);
    aborted = 1'b0;
    for (int i = 1; i <= v.npay && !aborted;
         i++) begin
      if (i == v.full_at) begin
        bus.fifo_full = sel;
        full_cnt = v.full_cyc;
      end
      if (i == v.sr_at) bus.soft_reset = sel;
      send_byte(exp_b[i], to);
      tmo += to;
      if (i == v.sr_at) begin
        bus.soft_reset = '0;
        aborted = 1'b1;
      end
    end
    bus.pkt_valid = 1'b0;
    if (aborted) begin
      bus.data_in = '0;
      idle(5);
    end else begin
      bus.data_in = par;
      got = 1'b0;
      for (int k = 0; k < 30 && !got; k++) begin
        idle(1);
        got = (pd_cnt != pd0);
      end
      if (!got) tmo++;
      bus.data_in = '0;
      idle(3);
    end
    seq_bad = 0;
    lfd_n = 0;
    we_or = '0;
    foreach (log_q[j]) begin
      if (j >= v.exp_wr) seq_bad++;
      else if (log_q[j].d !== exp_b[j]) seq_bad++;
      if (log_q[j].lfd) lfd_n++;
      we_or |= log_q[j].we;
    end
    chk({tag, " timeout"}, tmo, 0);
    chk({tag, " writes"}, log_q.size(), v.exp_wr);
    chk({tag, " byte_order"}, seq_bad, 0);
    chk({tag, " write_en_port"}, we_or, v.exp_we);
    chk({tag, " lfd_count"}, lfd_n, 1);
    if (log_q.size() > 0)
      chk({tag, " lfd_first"}, log_q[0].lfd, 1);
    chk({tag, " violations"}, viol_cnt, 0);
    chk({tag, " parity_done"}, pd_cnt - pd0,
        v.exp_pd);
    if (v.exp_pd > 0)
      chk({tag, " err_at_pdone"}, err_at_pd,
          v.exp_err);
    chk({tag, " err_hold"}, bus.err, v.exp_err);
    chk({tag, " busy_idle"}, bus.busy, 0);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'h39, 14, 0, 0, 0, 0, 1'b0,
               16, 3'b010, 1, 1'b0};
    tbl[1] = '{8'h0E, 3, 5, 0, 0, 0, 1'b0,
               5, 3'b100, 1, 1'b0};
    tbl[2] = '{8'h39, 14, 0, 6, 3, 0, 1'b0,
               16, 3'b010, 1, 1'b0};
    tbl[3] = '{8'h15, 5, 0, 0, 0, 0, 1'b1,
               7, 3'b010, 1, PAR_EN};
    tbl[4] = '{8'h39, 14, 0, 0, 0, 4, 1'b0,
               4, 3'b010, 0, 1'b0};
    tbl[5] = '{8'h08, 2, 0, 0, 0, 0, 1'b0,
               4, 3'b001, 1, 1'b0};

    bus.pkt_valid  = 1'b0;
    bus.data_in    = '0;
    bus.fifo_full  = '0;
    bus.fifo_empty = 3'b111;
    bus.soft_reset = '0;
    resetn = 1'b1;
    #1 resetn = 1'b0;
    #1;
    chk("rst data_out", bus.data_out, 0);
    chk("rst write_en", bus.write_en, 0);
    chk("rst lfd_state", bus.lfd_state, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst err", bus.err, 0);
    chk("rst parity_done", bus.parity_done, 0);
    @(posedge clock);
    @(posedge clock);
    #1 resetn = 1'b1;
    idle(1);

    foreach (tbl[i])
      run_packet(tbl[i], $sformatf("vec%0d", i));

    // header with reserved address is ignored
    log_q.delete();
    bus.pkt_valid = 1'b1;
    bus.data_in   = 8'h0F;
    idle(1);
    chk("addr3 busy", bus.busy, 0);
    bus.pkt_valid = 1'b0;
    bus.data_in   = '0;
    idle(3);
    chk("addr3 writes", log_q.size(), 0);
    chk("addr3 busy_after", bus.busy, 0);

    // reset in the middle of a payload
    begin
      int to, tmo;
      tmo = 0;
      send_byte(8'h39, to);
      tmo += to;
      for (int i = 1; i <= 5; i++) begin
        send_byte(pay(8'h39, i), to);
        tmo += to;
      end
      chk("mid timeout", tmo, 0);
      chk("mid pre write_en", bus.write_en,
          3'b010);
      resetn = 1'b0;
      #1;
      chk("mid data_out", bus.data_out, 0);
      chk("mid write_en", bus.write_en, 0);
      chk("mid lfd_state", bus.lfd_state, 0);
      chk("mid busy", bus.busy, 0);
      chk("mid err", bus.err, 0);
      chk("mid parity_done", bus.parity_done, 0);
      bus.pkt_valid = 1'b0;
      bus.data_in   = '0;
      idle(2);
      resetn = 1'b1;
      log_q.delete();
      idle(3);
      chk("mid no_partial", log_q.size(), 0);
      run_packet(tbl[0], "post_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
